serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
// - Parametrised bit-serial add/subtract unit; successor to the single-bit half-adder cell.
// - Processes one operand bit per clock through a registered carry.
// - Start/done handshake lets control logic issue WIDTH-bit adds without a wide carry chain.
// - Supports add and two's-complement subtract, with carry-out and signed-overflow flags.
// PARAMETERS
// - WIDTH   8   operand/result width in bits; legal range 2..32.
// PORTS
// - clk     in   1        rising-edge clock, single domain
// - rst     in   1        asynchronous, active-high reset
// - start   in   1        request; sampled only in IDLE or DONE
// - sub     in   1        0 = a+b+cin, 1 = a-b (cin ignored); latched at accept
// - cin     in   1        carry-in for add mode; latched at accept
// - a       in   WIDTH    operand A; latched at accept
// - b       in   WIDTH    operand B; latched at accept
// - busy    out  1        high while in RUN
// - done    out  1        one-cycle pulse; result valid
// - sum     out  WIDTH    result, held until the next accepted start completes
// - cout    out  1        final carry; for sub, 1 = no borrow (a>=b unsigned)
// - ovf     out  1        signed overflow: carry into MSB XOR carry out of MSB
// BEHAVIOUR
// - Reset (async assert, sync release): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; internal regs cleared.
// - States and transitions:
//   - IDLE -start-> RUN
//   - RUN -(cnt==WIDTH-1)-> DONE
//   - DONE -start-> RUN
//   - DONE -!start-> IDLE
// - Accept (edge E0, start=1 in IDLE/DONE):
//   - load shift regs A<=a and B<=(sub ? ~b : b); carry<=(sub ? 1 : cin); cnt<=0.
//   - busy=1 from E0; done=0.
// - RUN, each edge:
//   - s_bit = A[0]^B[0]^carry; carry <= majority(A[0],B[0],carry).
//   - shift A and B right by 1; shift s_bit into the MSB of the result shift reg; cnt++.
//   - At the MSB step, record c_msb_in = carry before update.
// - Completion at edge E_WIDTH:
//   - sum <= result shift reg incl. final bit; cout <= final carry; ovf <= c_msb_in ^ final carry.
//   - state=DONE, busy=0, done=1 for exactly one cycle.
//   - Latency: done high in the cycle after the WIDTH-th RUN edge, i.e. WIDTH+1 edges after accept.
// - Outputs sum/cout/ovf change only at completion; they stay stable during a following RUN.
// - start while busy is ignored (no queueing, no error).
// - start in DONE is accepted back-to-back: DONE->RUN and done drops. Throughput is one op per WIDTH+1 cycles.
// - sub/cin/a/b are don't-care except at the accept edge.
// - Arithmetic is modulo 2^WIDTH; cnt width = $clog2(WIDTH).
// - rst mid-RUN aborts immediately: all outputs return to reset values and there is no done pulse.
// STRUCTURE
// - Shared package serial_adder_pkg: state encoding localparams (S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2), WIDTH limits.
// - One sub-module, serial_fa_bit: combinational full-adder bit built from two half-adder stages plus an OR.
// - Top holds the FSM, counter, operand/result shift registers and the carry flop.
// TESTING (WIDTH=8)
// - Reset mid-op: rst asserted with no clock edge -> all outputs 0 at once; rst during RUN cycle 3 -> no done, state IDLE.
// - Add with carry-out: a=8'hFF, b=8'h01, cin=0, sub=0 -> done 9 edges after accept; sum=8'h00, cout=1, ovf=0.
// - Signed overflow: a=8'h7F, b=8'h01, sub=0 -> sum=8'h80, cout=0, ovf=1; a=8'h80, b=8'h80 -> sum=8'h00, cout=1, ovf=1.
// - Subtract: a=8'h05, b=8'h07, sub=1 -> sum=8'hFE, cout=0, ovf=0; a=8'h07, b=8'h05 -> sum=8'h02, cout=1.
// - Handshake: start held high through RUN -> ignored; a pulse in DONE with a=3, b=4, cin=1 -> immediate RUN; sum=8'h08 next done; prior sum stable meanwhile.
// - Exhaustive: all 4 combos of a[0], b[0] (a=8'h00/01, b=8'h00/01, cin=0) -> sum matches half-adder truth table, cout=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial add/subtract unit: FSM encoding and
// the supported operand width range.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/serial_fa_bit.sv
// Combinational full-adder bit: two cascaded half-adder stages, with the
// two stage carries merged by an OR.
module serial_fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p, g0, g1;

  assign p  = a ^ b;
  assign g0 = a & b;
  assign s  = p ^ ci;
  assign g1 = p & ci;
  assign co = g0 | g1;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit add/subtract: one operand bit per clock through a
// registered carry, with a start/busy/done handshake.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             s_bit, c_bit;
  logic             accept, last;

  serial_fa_bit u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (s_bit),
    .co (c_bit)
  );

  assign accept = start && (state != S_RUN);
  assign last   = (cnt == CNT_LAST);
  assign busy   = (state == S_RUN);
  assign done   = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last)  state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Subtract is a + ~b + 1; start is ignored while RUN, so accept never
  // collides with a shift step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= sub ? ~b : b;
      carry <= sub ? 1'b1 : cin;
      cnt   <= '0;
    end else if (busy) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= {s_bit, res_sr[WIDTH-1:1]};
      carry  <= c_bit;
      cnt    <= cnt + 1'b1;
      // On the MSB step, carry still holds the carry into the MSB.
      if (last) begin
        sum  <= {s_bit, res_sr[WIDTH-1:1]};
        cout <= c_bit;
        ovf  <= carry ^ c_bit;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8) with a result scoreboard.
module tb_serial_adder;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0, sub = 1'b0, cin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  int   errors = 0;
  int   checks = 0;
  res_t sb_q[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin),
    .a(a), .b(b), .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                 input logic rsub, input logic rcin);
    logic [W-1:0] bb;
    logic [W:0]   full;
    res_t         r;
    bb     = rsub ? ~rb : rb;
    full   = {1'b0, ra} + {1'b0, bb} + {{W{1'b0}}, (rsub ? 1'b1 : rcin)};
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (ra[W-1] == bb[W-1]) && (full[W-1] != ra[W-1]);
    return r;
  endfunction

  // Waits for done after an accept edge; checks latency and that the
  // previous result stays put while RUN is in progress.
  task automatic wait_done(input string tag, input logic [W-1:0] prev_sum);
    int   edges;
    res_t exp, obs;
    edges = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      edges++;
      if (done) break;
      check({tag, "_hold"}, {24'h0, sum}, {24'h0, prev_sum});
    end
    check({tag, "_latency"}, edges, W + 1);
    exp = sb_q.pop_front();
    obs = '{sum: sum, cout: cout, ovf: ovf};
    check({tag, "_result"}, {22'h0, obs}, {22'h0, exp});
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ra, input logic [W-1:0] rb,
                        input logic rsub, input logic rcin);
    logic [W-1:0] prev;
    @(negedge clk);
    start = 1'b1; a = ra; b = rb; sub = rsub; cin = rcin;
    @(posedge clk);
    sb_q.push_back(model(ra, rb, rsub, rcin));
    #1;
    prev = sum;
    check({tag, "_accept"}, {busy, done}, 2'b10);
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
    wait_done(tag, prev);
    @(posedge clk); #1;
    check({tag, "_to_idle"}, {busy, done}, 2'b00);
  endtask

  initial begin
    logic [W-1:0] prev;
    int           seen_done;

    // Reset state before any clock edge
    #1;
    check("reset_outs", {busy, done, sum, cout, ovf}, '0);
    @(negedge clk);
    rst = 1'b0;

    run_op("add_carry", 8'hFF, 8'h01, 1'b0, 1'b0);
    check("add_carry_const", {sum, cout, ovf}, {8'h00, 1'b1, 1'b0});
    run_op("ovf_pos",   8'h7F, 8'h01, 1'b0, 1'b0);
    check("ovf_pos_const", {sum, cout, ovf}, {8'h80, 1'b0, 1'b1});
    run_op("ovf_neg",   8'h80, 8'h80, 1'b0, 1'b0);
    run_op("sub_borrow", 8'h05, 8'h07, 1'b1, 1'b0);
    check("sub_borrow_const", {sum, cout, ovf}, {8'hFE, 1'b0, 1'b0});
    run_op("sub_ok",    8'h07, 8'h05, 1'b1, 1'b1);
    run_op("add_cin",   8'h3C, 8'hA5, 1'b0, 1'b1);

    for (int i = 0; i < 4; i++) begin
      run_op("ha", {7'h0, i[1]}, {7'h0, i[0]}, 1'b0, 1'b0);
      check("ha_truth", {sum, cout}, {6'h0, i[1] & i[0], i[1] ^ i[0], 1'b0});
    end

    // start held high through RUN with garbage operands: must be ignored
    @(negedge clk);
    start = 1'b1; a = 8'h10; b = 8'h20; sub = 1'b0; cin = 1'b0;
    @(posedge clk);
    sb_q.push_back(model(8'h10, 8'h20, 1'b0, 1'b0));
    for (int i = 0; i < W - 1; i++) begin
      @(negedge clk);
      a = 8'hAA; b = 8'h55; sub = 1'b1;
      @(posedge clk); #1;
      check("hold_start_busy", {busy, done}, 2'b10);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check("hold_start_done", done, 1'b1);
    check("hold_start_sum", sum, 8'h30);
    void'(sb_q.pop_front());
    prev = sum;

    // Back-to-back accept from DONE
    @(negedge clk);
    start = 1'b1; a = 8'd3; b = 8'd4; cin = 1'b1; sub = 1'b0;
    @(posedge clk);
    sb_q.push_back(model(8'd3, 8'd4, 1'b0, 1'b1));
    #1;
    check("b2b_accept", {busy, done}, 2'b10);
    @(negedge clk);
    start = 1'b0;
    wait_done("b2b", prev);
    check("b2b_sum", sum, 8'h08);

    // Async reset during RUN cycle 3
    @(negedge clk);
    start = 1'b1; a = 8'h12; b = 8'h34; sub = 1'b0; cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_run", {busy, done, sum, cout, ovf}, '0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen_done++;
    end
    check("rst_no_done", seen_done, 0);

    check("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
